uc_multiciclo_exc: RTL and testbench
====================================

Name: uc_multiciclo_exc

Overview:
- Parametrised successor to the multicycle MIPS control unit: the FSM that drives PC, IR, A/B, MDR, ALUOut, register bank, memory and ALU-source muxes of the multicycle datapath.
- Adds configurable memory wait states.
- Adds bne and addi.
- Adds precise exceptions (invalid opcode, arithmetic overflow) with EPC/Cause write and vectoring.
- Adds a break-halt state.
- Sits beside the datapath top level; its outputs connect one-to-one to datapath control inputs.

Parameters:
- MEM_WAIT, 1, extra cycles a memory read needs before data is valid (0..15).
- STATE_W, 5, width of State_out.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Overflow  in  1  ALU overflow flag (combinational, current cycle).
- PCWrite, PCWriteCond, BranchNe  out  1 each  PC load controls; datapath loads PC when PCWrite | (PCWriteCond & (zero ^ BranchNe)).
- IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst  out  1 each.
- ALUSrcA  out  1.
- ALUSrcB  out  2  (00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2).
- PCSource  out  2  (00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector).
- ALUOp  out  3  (000 add, 001 sub, 010 decode Funct).
- AWrite, BWrite, ALUOutWrite, MDRWrite, EPCWrite, CauseWrite  out  1 each.
- Cause  out  2  (00 none, 01 invalid opcode, 10 overflow).
- Halt  out  1  high while in HALT.
- State_out  out  STATE_W  current state encoding.

Behaviour:
- Reset == 0 at a rising edge: state := RST (0), wait counter := 0. All outputs are pure functions of state (Moore), except EXEC-state branching on Overflow. In RST every output is 0. Reset overrides any state, including mid-wait and HALT.
- Unlisted outputs are 0 in each state.
- State encodings: RST 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12, EXC 13, HALT 14.
- RST -> FETCH unconditionally.
- FETCH (MEM_WAIT+1 cycles):
  - IorD=0, MemRead=1 throughout.
  - Counter loads MEM_WAIT on entry and decrements.
  - Final cycle (counter==0): IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, then -> DECODE.
  - MEM_WAIT=0 gives a single-cycle FETCH.
- DECODE:
  - AWrite=BWrite=1; ALUSrcA=0, ALUSrcB=11, ALUOp=000, ALUOutWrite=1 (branch target).
  - Dispatch on Op:
    - 0x00 with Funct 0x0D -> HALT.
    - 0x00 other -> R_EXEC.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x08 -> I_EXEC.
    - 0x04 or 0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - anything else -> EXC with Cause 01.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000, ALUOutWrite=1. Then lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1 for MEM_WAIT+1 cycles; MDRWrite=1 in final cycle -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 (one cycle) -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010, ALUOutWrite=1. If Overflow and Funct is 0x20 or 0x22 -> EXC (Cause 10), else -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=000, ALUOutWrite=1. Overflow -> EXC (Cause 10), else -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNe=(Op==0x05) -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- EXC (one cycle):
  - EPCWrite=1 with ALUSrcA=0, ALUSrcB=01, ALUOp=001 (EPC := PC-4).
  - CauseWrite=1, Cause held from a cause register latched on the entering transition.
  - PCWrite=1, PCSource=11 -> FETCH.
  - Cause register clears to 00 on leaving EXC.
- HALT: Halt=1, no writes; stays until reset.
- An overflowing exception never asserts RegWrite: the WB state is skipped.

Test Plan:
- Reset held low 3 cycles mid-FETCH, then released -> State_out 0 for one cycle, then 1; all outputs 0 in state 0.
- MEM_WAIT=2, add with no overflow (Op 0x00, Funct 0x20) -> FETCH lasts 3 cycles, IRWrite and PCWrite only in the 3rd; then states 2,7,8,1, with RegWrite=1 and RegDst=1 in state 8.
- lw (Op 0x23), MEM_WAIT=1 -> states 1,1,2,3,4,4,5; MDRWrite only in the 2nd cycle of state 4; MemtoReg=1 in state 5.
- bne (Op 0x05) -> in state 11 BranchNe=1, PCWriteCond=1, PCSource=01, ALUOp=001; beq (0x04) gives BranchNe=0.
- addi (Op 0x08) with Overflow=1 in I_EXEC -> next state 13 with EPCWrite=1, CauseWrite=1, Cause=10, PCSource=11; no RegWrite ever asserted; then state 1.
- Op 0x3F -> DECODE then EXC with Cause=01. Break (Op 0x00, Funct 0x0D) -> HALT (14), Halt=1 held for 20 cycles until Reset low.

Source files
------------

// File: rtl/uc_multiciclo_exc_if.sv
// Control bundle between the multicycle control unit (master) and its datapath (slave).
// Timing: every control is valid for the whole cycle the FSM sits in a state; the datapath acts on it at the next rising edge.
interface uc_multiciclo_exc_if #(
    parameter int STATE_W = 5
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Overflow;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic               RegWrite;
    logic               RegDst;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [2:0]         ALUOp;
    logic               AWrite;
    logic               BWrite;
    logic               ALUOutWrite;
    logic               MDRWrite;
    logic               EPCWrite;
    logic               CauseWrite;
    logic [1:0]         Cause;
    logic               Halt;
    logic [STATE_W-1:0] State_out;

    modport master (
        input  Op, Funct, Overflow,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
               AWrite, BWrite, ALUOutWrite, MDRWrite, EPCWrite, CauseWrite,
               Cause, Halt, State_out
    );

    modport slave (
        output Op, Funct, Overflow,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
               AWrite, BWrite, ALUOutWrite, MDRWrite, EPCWrite, CauseWrite,
               Cause, Halt, State_out
    );
endinterface

// File: rtl/uc_multiciclo_exc.sv
// Multicycle MIPS control FSM with memory wait states, bne/addi, precise exceptions and break-halt.
module uc_multiciclo_exc #(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 5
) (
    input logic               Clk,
    input logic               Reset,
    uc_multiciclo_exc_if.master bus
);
    typedef enum logic [4:0] {
        S_RST       = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_MEM_ADDR  = 5'd3,
        S_MEM_READ  = 5'd4,
        S_MEM_WB    = 5'd5,
        S_MEM_WRITE = 5'd6,
        S_R_EXEC    = 5'd7,
        S_R_WB      = 5'd8,
        S_I_EXEC    = 5'd9,
        S_I_WB      = 5'd10,
        S_BRANCH    = 5'd11,
        S_JUMP      = 5'd12,
        S_EXC       = 5'd13,
        S_HALT      = 5'd14
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    logic [1:0] exc_cause;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_RST;
            wait_q  <= 4'd0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        exc_cause       = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 3'b000;
        bus.AWrite      = 1'b0;
        bus.BWrite      = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.MDRWrite    = 1'b0;
        bus.EPCWrite    = 1'b0;
        bus.CauseWrite  = 1'b0;
        bus.Cause       = 2'b00;
        bus.Halt        = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                if (wait_q == 4'd0) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively while the opcode is decoded
                bus.AWrite      = 1'b1;
                bus.BWrite      = 1'b1;
                bus.ALUSrcB     = 2'b11;
                bus.ALUOutWrite = 1'b1;
                case (bus.Op)
                    6'h00:        state_d = (bus.Funct == 6'h0D) ? S_HALT : S_R_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h08:        state_d = S_I_EXEC;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        state_d   = S_EXC;
                        exc_cause = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.ALUOutWrite = 1'b1;
                state_d         = (bus.Op == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                if (wait_q == 4'd0) begin
                    bus.MDRWrite = 1'b1;
                    state_d      = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_R_EXEC: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b010;
                bus.ALUOutWrite = 1'b1;
                if (bus.Overflow && (bus.Funct == 6'h20 || bus.Funct == 6'h22)) begin
                    state_d   = S_EXC;
                    exc_cause = 2'b10;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_I_EXEC: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.ALUOutWrite = 1'b1;
                if (bus.Overflow) begin
                    state_d   = S_EXC;
                    exc_cause = 2'b10;
                end else begin
                    state_d = S_I_WB;
                end
            end
            S_I_WB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNe    = (bus.Op == 6'h05);
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_d      = S_FETCH;
            end
            S_EXC: begin
                // PC was already advanced in FETCH, so PC-4 is the faulting instruction
                bus.EPCWrite   = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUOp      = 3'b001;
                bus.CauseWrite = 1'b1;
                bus.Cause      = cause_q;
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'b11;
                state_d        = S_FETCH;
            end
            S_HALT: bus.Halt = 1'b1;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_q == S_FETCH || state_q == S_MEM_READ) && wait_q != 4'd0)
            wait_d = wait_q - 4'd1;
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM_READ))
            wait_d = WAIT_INIT;
        cause_d = cause_q;
        if (state_q == S_EXC)
            cause_d = 2'b00;
        if (state_d == S_EXC && state_q != S_EXC)
            cause_d = exc_cause;
    end

    assign bus.State_out = STATE_W'(state_q);
endmodule

// File: tb/tb_uc_multiciclo_exc.sv
// Bench for uc_multiciclo_exc: two instances (MEM_WAIT 2 and 1) against an instruction-level reference model.
module tb_uc_multiciclo_exc;
    typedef struct packed {
        logic [4:0] st;
        logic       pcw, pcwc, bne, iord, mr, mw, m2r, irw, rw, rdst, asa;
        logic [1:0] asb;
        logic [1:0] pcs;
        logic [2:0] aop;
        logic       aw, bw, aow, mdrw, epcw, causew;
        logic [1:0] cause;
        logic       halt;
    } ctl_t;

    localparam int W0 = 2;
    localparam int W1 = 1;
    localparam int ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_READ = 4, ST_MEM_WB = 5,
                   ST_MEM_WRITE = 6, ST_R_EXEC = 7, ST_R_WB = 8, ST_I_EXEC = 9, ST_I_WB = 10,
                   ST_BRANCH = 11, ST_JUMP = 12, ST_EXC = 13, ST_HALT = 14;

    logic       clk = 1'b0;
    logic       rst_a   [2];
    logic [5:0] op_a    [2];
    logic [5:0] funct_a [2];
    logic       ovf_a   [2];
    ctl_t       act0, act1;
    ctl_t       exp_q0[$];
    ctl_t       exp_q1[$];
    ctl_t       e0, e1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uc_multiciclo_exc_if #(.STATE_W(5)) bus0 ();
    uc_multiciclo_exc_if #(.STATE_W(5)) bus1 ();

    assign bus0.Op = op_a[0];
    assign bus0.Funct = funct_a[0];
    assign bus0.Overflow = ovf_a[0];
    assign bus1.Op = op_a[1];
    assign bus1.Funct = funct_a[1];
    assign bus1.Overflow = ovf_a[1];

    uc_multiciclo_exc #(.MEM_WAIT(W0), .STATE_W(5)) dut0 (.Clk(clk), .Reset(rst_a[0]), .bus(bus0));
    uc_multiciclo_exc #(.MEM_WAIT(W1), .STATE_W(5)) dut1 (.Clk(clk), .Reset(rst_a[1]), .bus(bus1));

    assign act0 = {bus0.State_out, bus0.PCWrite, bus0.PCWriteCond, bus0.BranchNe, bus0.IorD,
                   bus0.MemRead, bus0.MemWrite, bus0.MemtoReg, bus0.IRWrite, bus0.RegWrite,
                   bus0.RegDst, bus0.ALUSrcA, bus0.ALUSrcB, bus0.PCSource, bus0.ALUOp,
                   bus0.AWrite, bus0.BWrite, bus0.ALUOutWrite, bus0.MDRWrite, bus0.EPCWrite,
                   bus0.CauseWrite, bus0.Cause, bus0.Halt};
    assign act1 = {bus1.State_out, bus1.PCWrite, bus1.PCWriteCond, bus1.BranchNe, bus1.IorD,
                   bus1.MemRead, bus1.MemWrite, bus1.MemtoReg, bus1.IRWrite, bus1.RegWrite,
                   bus1.RegDst, bus1.ALUSrcA, bus1.ALUSrcB, bus1.PCSource, bus1.ALUOp,
                   bus1.AWrite, bus1.BWrite, bus1.ALUOutWrite, bus1.MDRWrite, bus1.EPCWrite,
                   bus1.CauseWrite, bus1.Cause, bus1.Halt};

    // Control word the datapath must see in a state (non-final wait cycles, no variant bits).
    function automatic ctl_t st_vec(input int st);
        ctl_t v;
        v = '0;
        v.st = 5'(st);
        case (st)
            ST_FETCH:     v.mr = 1'b1;
            ST_DECODE:    begin v.aw = 1'b1; v.bw = 1'b1; v.asb = 2'b11; v.aow = 1'b1; end
            ST_MEM_ADDR:  begin v.asa = 1'b1; v.asb = 2'b10; v.aow = 1'b1; end
            ST_MEM_READ:  begin v.iord = 1'b1; v.mr = 1'b1; end
            ST_MEM_WB:    begin v.rw = 1'b1; v.m2r = 1'b1; end
            ST_MEM_WRITE: begin v.iord = 1'b1; v.mw = 1'b1; end
            ST_R_EXEC:    begin v.asa = 1'b1; v.aop = 3'b010; v.aow = 1'b1; end
            ST_R_WB:      begin v.rw = 1'b1; v.rdst = 1'b1; end
            ST_I_EXEC:    begin v.asa = 1'b1; v.asb = 2'b10; v.aow = 1'b1; end
            ST_I_WB:      v.rw = 1'b1;
            ST_BRANCH:    begin v.asa = 1'b1; v.aop = 3'b001; v.pcwc = 1'b1; v.pcs = 2'b01; end
            ST_JUMP:      begin v.pcw = 1'b1; v.pcs = 2'b10; end
            ST_HALT:      v.halt = 1'b1;
            default:      v = '0;
        endcase
        return v;
    endfunction

    function automatic ctl_t exc_vec(input logic [1:0] cause);
        ctl_t v;
        v = '0;
        v.st = 5'(ST_EXC);
        v.epcw = 1'b1; v.asb = 2'b01; v.aop = 3'b001;
        v.causew = 1'b1; v.cause = cause; v.pcw = 1'b1; v.pcs = 2'b11;
        return v;
    endfunction

    function automatic void push(input int d, input ctl_t v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic void check(input int d, input ctl_t e, input ctl_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d ctl_word at %0t: got state %0d word %h, expected state %0d word %h",
                     d, $time, a.st, a, e.st, e);
        end
    endfunction

    task automatic drive(input int d, input logic rst, input logic [5:0] op, input logic [5:0] funct,
                         input logic ovf, input ctl_t e, input logic chk);
        @(negedge clk);
        rst_a[d] = rst;
        op_a[d] = op;
        funct_a[d] = funct;
        ovf_a[d] = ovf;
        #1;
        if (chk) push(d, e);
    endtask

    // The first low cycle still shows the interrupted state; reset acts at the following edge.
    task automatic do_reset(input int d, input int n, input logic chk_first, input ctl_t first);
        for (int i = 0; i < n; i++)
            drive(d, 1'b0, 6'($urandom), 6'($urandom), 1'($urandom),
                  (i == 0) ? first : ctl_t'(0), (i > 0) || chk_first);
        drive(d, 1'b1, 6'h00, 6'h00, 1'b0, ctl_t'(0), 1'b1);
    endtask

    task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] funct,
                             input logic ovf, input int abort_at, input int halt_hold);
        ctl_t plan[$];
        ctl_t v;
        int   w;
        int   xi;
        logic halted;
        w = (d == 0) ? W0 : W1;
        halted = 1'b0;
        for (int i = 0; i < w; i++) plan.push_back(st_vec(ST_FETCH));
        v = st_vec(ST_FETCH); v.irw = 1'b1; v.pcw = 1'b1; v.asb = 2'b01;
        plan.push_back(v);
        plan.push_back(st_vec(ST_DECODE));
        xi = plan.size();
        case (op)
            6'h00: begin
                if (funct == 6'h0D) halted = 1'b1;
                else begin
                    plan.push_back(st_vec(ST_R_EXEC));
                    if (ovf && (funct == 6'h20 || funct == 6'h22)) plan.push_back(exc_vec(2'b10));
                    else plan.push_back(st_vec(ST_R_WB));
                end
            end
            6'h23: begin
                plan.push_back(st_vec(ST_MEM_ADDR));
                for (int i = 0; i < w; i++) plan.push_back(st_vec(ST_MEM_READ));
                v = st_vec(ST_MEM_READ); v.mdrw = 1'b1;
                plan.push_back(v);
                plan.push_back(st_vec(ST_MEM_WB));
            end
            6'h2B: begin
                plan.push_back(st_vec(ST_MEM_ADDR));
                plan.push_back(st_vec(ST_MEM_WRITE));
            end
            6'h08: begin
                plan.push_back(st_vec(ST_I_EXEC));
                if (ovf) plan.push_back(exc_vec(2'b10));
                else plan.push_back(st_vec(ST_I_WB));
            end
            6'h04, 6'h05: begin
                v = st_vec(ST_BRANCH); v.bne = (op == 6'h05);
                plan.push_back(v);
            end
            6'h02: plan.push_back(st_vec(ST_JUMP));
            default: plan.push_back(exc_vec(2'b01));
        endcase
        foreach (plan[i]) begin
            if (i == abort_at) begin
                do_reset(d, 3, 1'b1, plan[i]);
                return;
            end
            drive(d, 1'b1, op, funct, (i == xi) ? ovf : 1'($urandom_range(0, 1)), plan[i], 1'b1);
        end
        if (halted) begin
            v = st_vec(ST_HALT);
            for (int i = 0; i < halt_hold; i++) drive(d, 1'b1, op, funct, 1'($urandom), v, 1'b1);
            do_reset(d, 2, 1'b1, v);
        end
    endtask

    task automatic run_dut(input int d);
        logic [5:0] op, funct;
        do_reset(d, 2, 1'b0, ctl_t'(0));
        run_instr(d, 6'h00, 6'h20, 1'b0, 1, 0);
        run_instr(d, 6'h00, 6'h20, 1'b0, -1, 0);
        run_instr(d, 6'h00, 6'h20, 1'b1, -1, 0);
        run_instr(d, 6'h00, 6'h22, 1'b1, -1, 0);
        run_instr(d, 6'h00, 6'h24, 1'b1, -1, 0);
        run_instr(d, 6'h23, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h2B, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h05, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h04, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h08, 6'h00, 1'b1, -1, 0);
        run_instr(d, 6'h08, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h02, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h3F, 6'h00, 1'b0, -1, 0);
        run_instr(d, 6'h00, 6'h0D, 1'b0, -1, 20);
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 6'h00;
                2:       op = 6'h23;
                3:       op = 6'h2B;
                4:       op = 6'h08;
                5:       op = 6'h04;
                6:       op = 6'h05;
                7:       op = 6'h02;
                default: op = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4, 5: funct = 6'h20;
                6, 7, 8, 9, 10:   funct = 6'h22;
                11:               funct = 6'h0D;
                default:          funct = 6'($urandom_range(0, 63));
            endcase
            run_instr(d, op, funct, 1'($urandom_range(0, 1)), -1, $urandom_range(1, 6));
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q0.size() > 0) begin
            e0 = exp_q0.pop_front();
            check(0, e0, act0);
        end
        if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check(1, e1, act1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b0;
            op_a[d] = 6'h00;
            funct_a[d] = 6'h00;
            ovf_a[d] = 1'b0;
        end
        fork
            run_dut(0);
            run_dut(1);
        join
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0",
                     exp_q0.size() + exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
